// File: rtl/key_direction_controller.sv
// key_direction_controller: turns PS/2 make codes into one committed heading per lightbike player
// Ports: clock, reset (async, active-high); scan_code/scan_valid from the PS/2 receiver;
//   map_keyset drives the shared keyset mapper, map_up/right/down/left return its scancodes
//   in the same cycle; tick commits pending headings; dir holds 2 bits per player
//   (0 up, 1 right, 2 down, 3 left); busy is high while scanning keysets; dropped pulses
//   when a byte arrives while busy.
// Optional: define LB_REVERSE_GUARD_EN to reject presses that would reverse a player.
module key_direction_controller #(
  parameter int NUM_PLAYERS = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 scan_code,
  input  logic                       scan_valid,
  output logic [2:0]                 map_keyset,
  input  logic [7:0]                 map_left,
  input  logic [7:0]                 map_right,
  input  logic [7:0]                 map_up,
  input  logic [7:0]                 map_down,
  input  logic                       tick,
  output logic [2*NUM_PLAYERS-1:0]   dir,
  output logic                       busy,
  output logic                       dropped
);
  typedef enum logic {IDLE, SCAN} state_t;
  localparam logic [7:0] DIR_RST = 8'h2D;
  localparam logic [1:0] LAST = 2'(NUM_PLAYERS - 1);
  state_t state_q, state_d;
  logic ext_q, ext_d, brk_q, brk_d, dropped_q, dropped_d, hit, rev;
  logic [7:0] code_q, code_d;
  logic [1:0] idx_q, idx_d, head;
  logic [2*NUM_PLAYERS-1:0] dir_q, dir_d, pend_q, pend_d;
  logic [NUM_PLAYERS-1:0] pv_q, pv_d;
  assign map_keyset = {1'b0, idx_q};
  assign busy = state_q == SCAN;
  assign dropped = dropped_q;
  assign dir = dir_q;
  assign hit = code_q == map_up || code_q == map_right || code_q == map_down || code_q == map_left;
  assign head = code_q == map_up ? 2'd0 : code_q == map_right ? 2'd1 : code_q == map_down ? 2'd2 : 2'd3;
`ifdef LB_REVERSE_GUARD_EN
  // Compare against the heading this player will hold after the edge, so a
  // commit landing in the same cycle is already accounted for.
  logic [1:0] cur;
  assign cur = tick && pv_q[idx_q] ? pend_q[{idx_q, 1'b0} +: 2] : dir_q[{idx_q, 1'b0} +: 2];
  assign rev = (head ^ cur) == 2'd2;
`else
  assign rev = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ext_d = ext_q;
    brk_d = brk_q;
    code_d = code_q;
    idx_d = idx_q;
    dropped_d = 1'b0;
    dir_d = dir_q;
    pend_d = pend_q;
    pv_d = pv_q;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (tick && pv_q[p]) begin
        dir_d[2*p +: 2] = pend_q[2*p +: 2];
        pv_d[p] = 1'b0;
      end
    if (state_q == IDLE) begin
      if (scan_valid) begin
        if (scan_code == 8'hE0) ext_d = 1'b1;
        else if (scan_code == 8'hF0) brk_d = 1'b1;
        else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!brk_q) begin
            code_d = scan_code;
            idx_d = 2'd0;
            state_d = SCAN;
          end
        end
      end
    end else begin
      dropped_d = scan_valid;
      if (hit) begin
        state_d = IDLE;
        if (!rev) begin
          pend_d[{idx_q, 1'b0} +: 2] = head;
          pv_d[idx_q] = 1'b1;
        end
      end else if (idx_q == LAST) state_d = IDLE;
      else idx_d = idx_q + 2'd1;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      code_q <= 8'h00;
      idx_q <= 2'd0;
      dropped_q <= 1'b0;
      dir_q <= DIR_RST[2*NUM_PLAYERS-1:0];
      pend_q <= '0;
      pv_q <= '0;
    end else begin
      state_q <= state_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      code_q <= code_d;
      idx_q <= idx_d;
      dropped_q <= dropped_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      pv_q <= pv_d;
    end
  end
endmodule

// File: tb/tb_key_direction_controller.sv
// tb_key_direction_controller: directed checks of scanning, commit, release, drop and reversal handling
module tb_key_direction_controller;
`ifdef LB_REVERSE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1, scan_valid = 1'b0, tick = 1'b0, busy, dropped;
  logic [7:0] scan_code = 8'h00, map_left, map_right, map_up, map_down, dir;
  logic [2:0] map_keyset;
  int checks = 0, errors = 0;
  key_direction_controller #(.NUM_PLAYERS(4)) dut (
    .clock(clock), .reset(reset), .scan_code(scan_code), .scan_valid(scan_valid),
    .map_keyset(map_keyset), .map_left(map_left), .map_right(map_right),
    .map_up(map_up), .map_down(map_down), .tick(tick), .dir(dir), .busy(busy), .dropped(dropped)
  );
  always #5 clock = ~clock;
  always_comb begin
    {map_up, map_right, map_down, map_left} = 32'h0;
    case (map_keyset)
      3'd0: {map_up, map_right, map_down, map_left} = {8'h1D, 8'h23, 8'h1B, 8'h1C};
      3'd1: {map_up, map_right, map_down, map_left} = {8'h75, 8'h74, 8'h72, 8'h6B};
      3'd2: {map_up, map_right, map_down, map_left} = {8'h43, 8'h4B, 8'h42, 8'h3B};
      3'd3: {map_up, map_right, map_down, map_left} = {8'h6C, 8'h7D, 8'h7A, 8'h69};
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clock);
  endtask
  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_valid = 1'b1;
    cyc();
    scan_valid = 1'b0;
  endtask
  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask
  initial begin
    cyc();
    check("rst_dir", dir, 8'h2D);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_ks", {5'd0, map_keyset}, 8'd0);
    check("rst_drop", {7'd0, dropped}, 8'd0);
    reset = 1'b0;
    cyc();
    send(8'h1D);
    check("w_busy", {7'd0, busy}, 8'd1);
    check("w_ks", {5'd0, map_keyset}, 8'd0);
    cyc();
    check("w_idle", {7'd0, busy}, 8'd0);
    repeat (10) cyc();
    check("w_pre_tick", dir, 8'h2D);
    pulse_tick();
    check("w_tick", dir, 8'h2C);
    send(8'h43);
    check("i_ks0", {5'd0, map_keyset}, 8'd0);
    cyc();
    check("i_ks1", {5'd0, map_keyset}, 8'd1);
    cyc();
    check("i_ks2", {5'd0, map_keyset}, 8'd2);
    check("i_busy3", {7'd0, busy}, 8'd1);
    cyc();
    check("i_idle", {7'd0, busy}, 8'd0);
    check("i_ks_hold", {5'd0, map_keyset}, 8'd2);
    pulse_tick();
    check("i_tick", dir, GUARD ? 8'h2C : 8'h0C);
    send(8'hF0);
    check("f0_busy", {7'd0, busy}, 8'd0);
    send(8'h1D);
    check("rel_busy", {7'd0, busy}, 8'd0);
    pulse_tick();
    check("rel_dir", dir, GUARD ? 8'h2C : 8'h0C);
    send(8'h23);
    cyc();
    pulse_tick();
    check("d_dir", dir, GUARD ? 8'h2D : 8'h0D);
    send(8'h1C);
    cyc();
    pulse_tick();
    check("rev_dir", dir, GUARD ? 8'h2D : 8'h0F);
    send(8'h7D);
    send(8'h1D);
    check("drop_pulse", {7'd0, dropped}, 8'd1);
    check("drop_ks", {5'd0, map_keyset}, 8'd1);
    cyc();
    check("drop_end", {7'd0, dropped}, 8'd0);
    cyc();
    check("drop_ks3", {5'd0, map_keyset}, 8'd3);
    cyc();
    check("drop_idle", {7'd0, busy}, 8'd0);
    pulse_tick();
    check("drop_dir", dir, GUARD ? 8'h6D : 8'h4F);
    send(8'h1B);
    cyc();
    send(8'h1D);
    pulse_tick();
    check("same_tick", dir, GUARD ? 8'h6E : 8'h4E);
    pulse_tick();
    check("same_next", dir, GUARD ? 8'h6E : 8'h4C);
    send(8'hE0);
    check("e0_busy", {7'd0, busy}, 8'd0);
    send(8'h72);
    check("ext_busy", {7'd0, busy}, 8'd1);
    repeat (2) cyc();
    check("ext_idle", {7'd0, busy}, 8'd0);
    pulse_tick();
    check("ext_dir", dir, GUARD ? 8'h6A : 8'h48);
    send(8'h7D);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_dir", dir, 8'h2D);
    check("mid_rst_ks", {5'd0, map_keyset}, 8'd0);
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    pulse_tick();
    check("post_rst_dir", dir, 8'h2D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_direction_controller.md
Name: key_direction_controller

Overview:
- Turns the PS/2 scancode byte stream into one committed heading per lightbike player.
- Time-multiplexes the single shared combinational keyset-to-scancode mapper by stepping its keyset select over all players, one per cycle, after each make code.
- Buffers one pending heading per player and commits all pending headings on the game-step tick.
- Sits between the PS/2 receiver and the game-state/movement logic.

Parameters:
NUM_PLAYERS, 4, number of players/keysets scanned (1..4); keyset index = player index.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
scan_code  input  8  received PS/2 byte
scan_valid  input  1  one-cycle strobe, scan_code valid
map_keyset  output  3  keyset select driven to shared mapper
map_left  input  8  mapper left scancode for map_keyset (same-cycle, combinational)
map_right  input  8  mapper right scancode
map_up  input  8  mapper up scancode
map_down  input  8  mapper down scancode
tick  input  1  one-cycle game-step strobe; commits pending headings
dir  output  2*NUM_PLAYERS  committed heading, player p at bits [2p+1:2p]
busy  output  1  high while in SCAN
dropped  output  1  one-cycle pulse when a byte arrives while busy

Behaviour:
- Heading encoding: 0 up, 1 right, 2 down, 3 left.
- A reversal is a new heading where (new XOR current) == 2.
- Reset values (async):
  - dir: p0=1 (right), p1=3 (left), p2=2 (down), p3=0 (up).
  - All pending_valid=0; state IDLE; ext=0, brk=0.
  - map_keyset=0, busy=0, dropped=0.
- State IDLE, on scan_valid:
  - 0xE0: set ext. Stay in IDLE.
  - 0xF0: set brk. Stay in IDLE.
  - Other byte with brk=1: release code. Clear ext and brk, ignore the byte.
  - Other byte with brk=0: latch it into code_q, clear ext and brk, set idx=0, go to SCAN.
  - ext is only stripped. Matching ignores ext, so 0x6B and E0 0x6B both match 0x6B.
- State SCAN:
  - map_keyset=idx.
  - Compare code_q with map_up, map_right, map_down, map_left, in that priority order.
  - On a match, if the heading passes the reversal check, write pending[idx]=heading and set pending_valid[idx]=1. A newer accepted press overwrites an older pending one.
  - On a match (accepted or rejected), return to IDLE next cycle (first match wins).
  - No match and idx==NUM_PLAYERS-1: return to IDLE.
  - Otherwise idx increments.
  - Worst-case latency from make-code strobe to pending update: NUM_PLAYERS cycles. busy is high for the whole of SCAN.
  - map_keyset holds its last value in IDLE.
- Reversal check: the new heading is compared against the player's committed dir as it will be after this cycle, including a commit happening in the same cycle.
- Tick, in any state:
  - For every p with pending_valid[p]=1: dir[p] <= pending[p], pending_valid[p] <= 0.
  - If tick and a SCAN match for player p fall in the same cycle:
    - The existing pending value commits.
    - The new match is checked against that newly committed heading.
    - If accepted, it lands as pending_valid=1 for the next tick.
- scan_valid during SCAN: the byte is discarded and dropped pulses 1 cycle. ext, brk and the scan in progress are unaffected.
- Reset mid-SCAN: everything returns to reset values immediately and the latched code is lost.

Optional Feature:
- Macro LB_REVERSE_GUARD_EN.
- Defined: the reversal check above is applied. A reversing press is matched (scan ends) but is not written to pending, and any existing pending value is kept.
- Undefined: no reversal check. Every matched press is written to pending.

Test Plan:
- Reset: dir = {p3:0, p2:2, p1:3, p0:1}, busy=0, map_keyset=0.
- Byte 0x1D, then tick 10 cycles later:
  - busy=1 for exactly 1 cycle with map_keyset=0.
  - p0 pending=up; dir p0 changes 1->0 only on the tick.
- Byte 0x43 (keyset 2 up):
  - map_keyset sequences 0,1,2; busy=1 for 3 cycles.
  - After tick, p2 = 0.
- Release sequence F0 1D: no pending change, dir unchanged after tick.
- With LB_REVERSE_GUARD_EN, p0 dir=right, byte 0x1C (left): pending not set, dir stays 1 after tick.
  - Without the macro: dir becomes 3 after tick.
- Second byte strobed on the cycle after a make code, while busy: dropped=1 for 1 cycle, second byte has no effect.
- Byte 0x1D matching on the same cycle as tick, with pending p0=down already queued:
  - That tick commits dir p0=down.
  - 0x1D (up) is then a reversal: rejected with the guard, pending up without it.
